// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that lends one external combinational ALU to NREQ requesters.
// state | meaning:  IDLE = grant scan  |  EXEC = ALU driven, result captured  |  RESP = result held for owner
module alu_share_arbiter #(
    parameter int NREQ = 2,
    parameter int DW   = 64,
    parameter int OPW  = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*DW-1:0] req_a,
    input  logic [NREQ*DW-1:0] req_b,
    input  logic [NREQ*OPW-1:0] req_op,
    output logic [NREQ-1:0]    resp_valid,
    input  logic [NREQ-1:0]    resp_ready,
    output logic [DW-1:0]      resp_data,
    output logic [DW-1:0]      alu_a,
    output logic [DW-1:0]      alu_b,
    output logic [OPW-1:0]     alu_op,
    input  logic [DW-1:0]      alu_res
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     rr_ptr, rr_ptr_nxt;
    logic [PW-1:0]     owner, owner_nxt;
    logic [PW-1:0]     gnt_idx, gnt_off;
    logic [PW:0]       gnt_sum;
    logic              gnt_any;
    logic              accept;
    logic [2*NREQ-1:0] rot;
    logic [DW-1:0]     a_q, b_q, res_q, a_sel, b_sel;
    logic [OPW-1:0]    op_q, op_sel;

    // Rotate the request vector so bit 0 is the requester at rr_ptr; first set bit wins.
    always_comb begin
        rot     = {req_valid, req_valid} >> rr_ptr;
        gnt_any = 1'b0;
        gnt_off = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_any && rot[k]) begin
                gnt_any = 1'b1;
                gnt_off = PW'(k);
            end
        end
        gnt_sum = {1'b0, rr_ptr} + {1'b0, gnt_off};
        if (gnt_sum >= (PW+1)'(NREQ))
            gnt_idx = PW'(gnt_sum - (PW+1)'(NREQ));
        else
            gnt_idx = gnt_sum[PW-1:0];
    end

    assign accept = (state == IDLE) && gnt_any;

    always_comb begin
        a_sel  = '0;
        b_sel  = '0;
        op_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == PW'(i)) begin
                a_sel  = req_a[i*DW +: DW];
                b_sel  = req_b[i*DW +: DW];
                op_sel = req_op[i*OPW +: OPW];
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        owner_nxt  = owner;
        case (state)
            IDLE: begin
                if (gnt_any) begin
                    state_nxt  = EXEC;
                    owner_nxt  = gnt_idx;
                    rr_ptr_nxt = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + PW'(1);
                end
            end
            EXEC:    state_nxt = RESP;
            RESP:    if (resp_ready[owner]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
            owner  <= owner_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            res_q <= '0;
        end else begin
            if (accept) begin
                a_q  <= a_sel;
                b_q  <= b_sel;
                op_q <= op_sel;
            end
            if (state == EXEC)
                res_q <= alu_res;
        end
    end

    // ALU inputs are forced to zero outside EXEC so the shared datapath stays quiet.
    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        resp_data  = '0;
        alu_a      = '0;
        alu_b      = '0;
        alu_op     = '0;
        if (accept)
            req_ready = NREQ'(1) << gnt_idx;
        if (state == EXEC) begin
            alu_a  = a_q;
            alu_b  = b_q;
            alu_op = op_q;
        end
        if (state == RESP) begin
            resp_valid = NREQ'(1) << owner;
            resp_data  = res_q;
        end
    end
endmodule
